lifting_pair_unit: RTL

Multi-lane, fully handshaked DWT lifting stage computing one predict step and one update step per line of even/odd sample pairs. It generalises the single-pair 9/7 processing unit with parametrised coefficients, Lanes parallel channels and true valid/ready backpressure. It also adds symmetric boundary extension and an end-of-line flush. It sits between the even/odd deinterleaver and the next lifting stage or scaler in the horizontal DWT chain.

---
 rtl/lifting_pair_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/lifting_pair_unit.sv
// lifting_pair_unit: multi-lane handshaked DWT predict/update lifting stage with symmetric line extension
// Ports: clk_i rising-edge clock; rst_i async active-low reset.
//   s_valid_i/s_ready_o/s_sof_i/s_eol_i/s_data_i : input pair stream, lane l = {odd, even}
//   m_valid_o/m_ready_i/m_sof_o/m_eol_o/m_data_o : output pair stream, lane l = {d, s}
module lifting_pair_unit #(
  parameter int  DataWidth = 16,
  parameter int  Point     = 10,
  parameter int  CoefWidth = 18,
  parameter real Alpha     = -1.586134342,
  parameter real Beta      = -0.052980118,
  parameter int  Lanes     = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic                           s_sof_i,
  input  logic                           s_eol_i,
  input  logic [Lanes*2*DataWidth-1:0]   s_data_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic                           m_sof_o,
  output logic                           m_eol_o,
  output logic [Lanes*2*DataWidth-1:0]   m_data_o
);
  localparam int PW   = CoefWidth + DataWidth + 1;
  localparam int AW   = PW + 1;
  localparam int IntA = $rtoi(Alpha * (2.0 ** Point) + (Alpha < 0.0 ? -0.5 : 0.5));
  localparam int IntB = $rtoi(Beta * (2.0 ** Point) + (Beta < 0.0 ? -0.5 : 0.5));
  localparam logic signed [CoefWidth-1:0] CoefA = CoefWidth'(IntA);
  localparam logic signed [CoefWidth-1:0] CoefB = CoefWidth'(IntB);
  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} state_t;
  state_t r_state, w_state_nx;
  logic signed [DataWidth-1:0] r_e [Lanes];
  logic signed [DataWidth-1:0] r_o [Lanes];
  logic signed [DataWidth-1:0] r_pd [Lanes];
  logic signed [DataWidth-1:0] w_d [Lanes];
  logic signed [DataWidth-1:0] w_s [Lanes];
  logic r_first, r_sof, r_mvalid, r_msof, r_meol;
  logic [Lanes*2*DataWidth-1:0] r_mdata;
  logic w_free, w_acc, w_flush_go, w_load;
  function automatic logic signed [DataWidth-1:0] sat(input logic signed [AW-1:0] v);
    return (&v[AW-1:DataWidth-1] || !(|v[AW-1:DataWidth-1])) ? v[DataWidth-1:0]
         : {v[AW-1], {(DataWidth-1){!v[AW-1]}}};
  endfunction
  assign w_free     = !r_mvalid || m_ready_i;
  assign s_ready_o  = rst_i && (r_state != FLUSH) && w_free;
  assign w_acc      = s_valid_i && s_ready_o;
  assign w_flush_go = (r_state == FLUSH) && w_free;
  assign w_load     = (w_acc && r_state == HOLD) || w_flush_go;
  assign m_valid_o  = r_mvalid;
  assign m_sof_o    = r_msof;
  assign m_eol_o    = r_meol;
  assign m_data_o   = r_mdata;
  // Result for the pending pair: next even is the incoming pair's, or the pending one mirrored at line end.
  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    logic signed [DataWidth-1:0] w_enx, w_dp;
    logic signed [DataWidth:0]   w_esum, w_dsum;
    logic signed [PW-1:0]        w_pa, w_pb;
    assign w_enx  = (r_state == FLUSH) ? r_e[l] : s_data_i[l*2*DataWidth +: DataWidth];
    assign w_esum = (DataWidth+1)'(r_e[l]) + (DataWidth+1)'(w_enx);
    assign w_pa   = PW'(CoefA) * PW'(w_esum);
    assign w_d[l] = sat(AW'(w_pa >>> Point) + AW'(r_o[l]));
    assign w_dp   = r_first ? w_d[l] : r_pd[l];
    assign w_dsum = (DataWidth+1)'(w_dp) + (DataWidth+1)'(w_d[l]);
    assign w_pb   = PW'(CoefB) * PW'(w_dsum);
    assign w_s[l] = sat(AW'(w_pb >>> Point) + AW'(r_e[l]));
  end
  always_comb begin
    w_state_nx = r_state;
    if (w_acc) w_state_nx = s_eol_i ? FLUSH : HOLD;
    else if (w_flush_go) w_state_nx = EMPTY;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= EMPTY;
      r_first  <= 1'b0;
      r_sof    <= 1'b0;
      r_mvalid <= 1'b0;
      r_msof   <= 1'b0;
      r_meol   <= 1'b0;
      r_mdata  <= '0;
      for (int l = 0; l < Lanes; l++) begin
        r_e[l]  <= '0;
        r_o[l]  <= '0;
        r_pd[l] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      if (w_acc) begin
        r_sof   <= s_sof_i;
        r_first <= (r_state == EMPTY);
        for (int l = 0; l < Lanes; l++) begin
          r_e[l] <= s_data_i[l*2*DataWidth +: DataWidth];
          r_o[l] <= s_data_i[l*2*DataWidth+DataWidth +: DataWidth];
        end
      end else if (w_flush_go) r_first <= 1'b0;
      if (w_load) for (int l = 0; l < Lanes; l++) r_pd[l] <= w_d[l];
      if (w_free) begin
        r_mvalid <= w_load;
        r_msof   <= w_load && r_sof;
        r_meol   <= w_flush_go;
        if (w_load) for (int l = 0; l < Lanes; l++) r_mdata[l*2*DataWidth +: 2*DataWidth] <= {w_d[l], w_s[l]};
      end
    end
  end
endmodule
